mmu_unit: RTL and testbench
===========================

# mmu_unit

Address-translation unit between the CPU core's data bus and the system bus. It registers the core's virtual address and access type when `addrValid` is asserted. It then drives the physical address, an I/O (uncached) flag and an exception code. Translation uses fixed MIPS-style kernel segments plus an 8-entry fully-associative TLB, managed by the core through a small register/command port.

## Interface
Parameters:
- `TAG`, default "MMU": name string, debug messages only.

Ports:
- `clk` in 1: clock; all state changes on rising edge.
- `res` in 1: reset; synchronous, active-low.
- `addrValid` in 1: capture `vAddr`/`mmu_accessType` at this edge.
- `vAddr` in 32: virtual address from core.
- `mmu_accessType` in 2: `MEM_ACCESS` encoding, 0 NONE, 1 R, 2 W, 3 X.
- `pAddr` out 32: physical address.
- `db_io` out 1: access is I/O / uncached.
- `mmu_reg` in 2: register select, 0 INDEX, 1 ENTRY_HI, 2 ENTRY_LO, 3 BAD_VADDR.
- `mmu_dataIn` in 32: write data from core.
- `mmu_dataOut` out 32: read data to core.
- `mmu_cmd` in 3: 0 NONE, 1 WRITE_REG, 2 TLBWI, 3 TLBR, 4 TLBP; 5–7 act as NONE.
- `mmu_exception` out 2: 0 NONE, 1 TLB_MISS, 2 INVALID, 3 MODIFY.

## Operation
- Latch: at an edge with `addrValid`=1, store `va`<=`vAddr` and `at`<=`mmu_accessType`. All translation outputs are combinational from `va`, `at` and the TLB.
- Segments, by `va[31:29]`:
  - 100 (kseg0): `pAddr`={3'b0,`va[28:0]`}, `db_io`=0, never an exception.
  - 101 (kseg1): same mapping, `db_io`=1, never an exception.
  - All other values (kuseg, kseg2): mapped through the TLB.
- TLB entry format:
  - VPN[19:0], PFN[19:0], flags IO, D (writable), V.
  - Entry valid-for-match bit E, cleared by reset.
  - Hit: E=1 and VPN==`va[31:12]`. With several hits, the lowest index wins.
- Mapped hit:
  - `pAddr`={PFN,`va[11:0]`}, `db_io`=IO.
  - V=0 → INVALID.
  - Otherwise `at`==W and D=0 → MODIFY.
  - Otherwise NONE.
- Mapped miss: TLB_MISS, `pAddr`=0, `db_io`=0.
- `at`==NONE forces `mmu_exception`=NONE; `pAddr`/`db_io` still follow the rules above.
- Registers:
  - INDEX[2:0], plus bit31 = probe-miss flag.
  - ENTRY_HI: [31:12] VPN; bits [11:0] read 0.
  - ENTRY_LO: [31:12] PFN, bit2 IO, bit1 D, bit0 V; other bits read 0.
  - BAD_VADDR: read-only.
- `mmu_dataOut` = selected register, combinational, independent of `mmu_cmd`.
- Commands, executed at the edge:
  - WRITE_REG: selected register <= `mmu_dataIn` (masked to its fields). A write to BAD_VADDR is ignored.
  - TLBWI: entry[INDEX[2:0]] <= {ENTRY_HI.VPN, ENTRY_LO fields}, E=1.
  - TLBR: ENTRY_HI/ENTRY_LO <= entry[INDEX[2:0]].
  - TLBP: match ENTRY_HI.VPN against entries with E=1. Hit → INDEX={1'b0,28'b0,idx}. Miss → INDEX[31]=1, INDEX[2:0] unchanged.
- BAD_VADDR <= `va` at every edge where `mmu_exception`≠NONE.

## Timing
- Reset (`res`=0 at an edge):
  - `va`=0, `at`=NONE.
  - All E=0.
  - INDEX, ENTRY_HI, ENTRY_LO and BAD_VADDR = 0.
  - Outputs after reset: `pAddr`=0, `db_io`=0, `mmu_exception`=NONE, `mmu_dataOut`=0 (with `mmu_reg`=0).
- Reset has priority over `addrValid` and `mmu_cmd` at the same edge. Reset mid-access drops the access.
- Latency: `pAddr`/`db_io`/`mmu_exception` are valid in the cycle after the `addrValid` edge. They hold until the next `addrValid` edge.
- The core reads them one cycle later, during bus access.
- A TLB/register update at edge N is reflected in outputs from cycle N+1, including for an already-latched address.
- The same edge may carry `addrValid` and `mmu_cmd`. The address latches independently, and translation after that edge uses the updated TLB.
- WRITE_REG followed by a read: the new value is visible on `mmu_dataOut` the next cycle.

## Test plan
- Reset, then `addrValid` with `vAddr`=0x8000_1234, R → `pAddr`=0x0000_1234, `db_io`=0, exception NONE. Repeat with 0xBFC0_0000 → `pAddr`=0x1FC0_0000, `db_io`=1.
- After reset, `addrValid` with `vAddr`=0x0040_0010, X → TLB_MISS. BAD_VADDR reads 0x0040_0010 afterwards.
- Map a page via WRITE_REG INDEX=3, ENTRY_HI=0x0040_0000, ENTRY_LO=0x0123_4007, then TLBWI. Access R at 0x0040_0ABC → `pAddr`=0x0123_4ABC, `db_io`=1, NONE.
- Same entry rewritten with ENTRY_LO=0x0123_4001; write 0x0040_0000 → MODIFY. With ENTRY_LO=0x0123_4000, read → INVALID, `pAddr`=0x0123_4000.
- TLBP with ENTRY_HI=0x0040_0000 → INDEX=3. TLBP with 0x0050_0000 → INDEX=0x8000_0003. TLBR at index 3 returns the written ENTRY_HI/ENTRY_LO.
- Assert `res`=0 while a latched access shows TLB_MISS → exception NONE next cycle. Prior mapping then misses because all E are cleared.

Source files
------------

// File: rtl/mmu_unit.sv
// Address-translation unit: latches the core's virtual address, maps it through fixed
// kernel segments or an 8-entry fully-associative TLB, and exposes TLB management registers.
module mmu_unit #(
  parameter string TAG = "MMU"
) (
  input  logic        clk,
  input  logic        res,
  input  logic        addrValid,
  input  logic [31:0] vAddr,
  input  logic [1:0]  mmu_accessType,
  output logic [31:0] pAddr,
  output logic        db_io,
  input  logic [1:0]  mmu_reg,
  input  logic [31:0] mmu_dataIn,
  output logic [31:0] mmu_dataOut,
  input  logic [2:0]  mmu_cmd,
  output logic [1:0]  mmu_exception
);

  localparam logic [1:0] AT_NONE = 2'd0;
  localparam logic [1:0] AT_W    = 2'd2;

  localparam logic [1:0] REG_INDEX    = 2'd0;
  localparam logic [1:0] REG_ENTRY_HI = 2'd1;
  localparam logic [1:0] REG_ENTRY_LO = 2'd2;
  localparam logic [1:0] REG_BAD      = 2'd3;

  localparam logic [2:0] CMD_WRITE_REG = 3'd1;
  localparam logic [2:0] CMD_TLBWI     = 3'd2;
  localparam logic [2:0] CMD_TLBR      = 3'd3;
  localparam logic [2:0] CMD_TLBP      = 3'd4;

  localparam logic [1:0] EXC_NONE    = 2'd0;
  localparam logic [1:0] EXC_MISS    = 2'd1;
  localparam logic [1:0] EXC_INVALID = 2'd2;
  localparam logic [1:0] EXC_MODIFY  = 2'd3;

  localparam int NUM_ENTRIES = 8;

  // The name only tags debug output in simulation models; it has no hardware meaning.
  if ($bits(TAG) == 0) begin : g_untagged
  end

  // Latched access
  logic [31:0] va_q;
  logic [1:0]  at_q;

  // Management registers
  logic        index_miss_q;
  logic [2:0]  index_q;
  logic [19:0] hi_vpn_q;
  logic [19:0] lo_pfn_q;
  logic        lo_io_q, lo_d_q, lo_v_q;
  logic [31:0] bad_vaddr_q;

  // TLB storage
  logic [19:0] tlb_vpn_q [NUM_ENTRIES];
  logic [19:0] tlb_pfn_q [NUM_ENTRIES];
  logic        tlb_io_q  [NUM_ENTRIES];
  logic        tlb_d_q   [NUM_ENTRIES];
  logic        tlb_v_q   [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] tlb_e_q;

  logic       xlat_hit, probe_hit;
  logic [2:0] xlat_idx, probe_idx;

  // Mask bits of the write data that no register field holds.
  logic unused_data_bits;
  assign unused_data_bits = ^mmu_dataIn[11:3];

  // Scanning from the top down lets the lowest matching index win.
  always_comb begin
    xlat_hit  = 1'b0;
    xlat_idx  = '0;
    probe_hit = 1'b0;
    probe_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (tlb_e_q[i] && tlb_vpn_q[i] == va_q[31:12]) begin
        xlat_hit = 1'b1;
        xlat_idx = 3'(i);
      end
      if (tlb_e_q[i] && tlb_vpn_q[i] == hi_vpn_q) begin
        probe_hit = 1'b1;
        probe_idx = 3'(i);
      end
    end
  end

  always_comb begin
    pAddr         = '0;
    db_io         = 1'b0;
    mmu_exception = EXC_NONE;
    if (va_q[31:29] == 3'b100 || va_q[31:29] == 3'b101) begin
      pAddr = {3'b000, va_q[28:0]};
      db_io = va_q[29];
    end else if (xlat_hit) begin
      pAddr = {tlb_pfn_q[xlat_idx], va_q[11:0]};
      db_io = tlb_io_q[xlat_idx];
      if (!tlb_v_q[xlat_idx]) begin
        mmu_exception = EXC_INVALID;
      end else if (at_q == AT_W && !tlb_d_q[xlat_idx]) begin
        mmu_exception = EXC_MODIFY;
      end
    end else begin
      mmu_exception = EXC_MISS;
    end
    if (at_q == AT_NONE) begin
      mmu_exception = EXC_NONE;
    end
  end

  always_comb begin
    mmu_dataOut = '0;
    case (mmu_reg)
      REG_INDEX:    mmu_dataOut = {index_miss_q, 28'd0, index_q};
      REG_ENTRY_HI: mmu_dataOut = {hi_vpn_q, 12'd0};
      REG_ENTRY_LO: mmu_dataOut = {lo_pfn_q, 9'd0, lo_io_q, lo_d_q, lo_v_q};
      default:      mmu_dataOut = bad_vaddr_q;
    endcase
  end

  // NOTE: only the match-enable bits are reset; the entry payload is plain storage whose
  // contents are meaningless until TLBWI sets E, so it needs no reset network.
  always_ff @(posedge clk) begin
    if (res && mmu_cmd == CMD_TLBWI) begin
      tlb_vpn_q[index_q] <= hi_vpn_q;
      tlb_pfn_q[index_q] <= lo_pfn_q;
      tlb_io_q[index_q]  <= lo_io_q;
      tlb_d_q[index_q]   <= lo_d_q;
      tlb_v_q[index_q]   <= lo_v_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      va_q         <= '0;
      at_q         <= AT_NONE;
      tlb_e_q      <= '0;
      index_miss_q <= 1'b0;
      index_q      <= '0;
      hi_vpn_q     <= '0;
      lo_pfn_q     <= '0;
      lo_io_q      <= 1'b0;
      lo_d_q       <= 1'b0;
      lo_v_q       <= 1'b0;
      bad_vaddr_q  <= '0;
    end else begin
      if (addrValid) begin
        va_q <= vAddr;
        at_q <= mmu_accessType;
      end
      if (mmu_exception != EXC_NONE) begin
        bad_vaddr_q <= va_q;
      end
      case (mmu_cmd)
        CMD_WRITE_REG: begin
          case (mmu_reg)
            REG_INDEX: begin
              index_miss_q <= mmu_dataIn[31];
              index_q      <= mmu_dataIn[2:0];
            end
            REG_ENTRY_HI: hi_vpn_q <= mmu_dataIn[31:12];
            REG_ENTRY_LO: begin
              lo_pfn_q <= mmu_dataIn[31:12];
              lo_io_q  <= mmu_dataIn[2];
              lo_d_q   <= mmu_dataIn[1];
              lo_v_q   <= mmu_dataIn[0];
            end
            default: ;
          endcase
        end
        CMD_TLBWI: tlb_e_q[index_q] <= 1'b1;
        CMD_TLBR: begin
          hi_vpn_q <= tlb_vpn_q[index_q];
          lo_pfn_q <= tlb_pfn_q[index_q];
          lo_io_q  <= tlb_io_q[index_q];
          lo_d_q   <= tlb_d_q[index_q];
          lo_v_q   <= tlb_v_q[index_q];
        end
        CMD_TLBP: begin
          if (probe_hit) begin
            index_miss_q <= 1'b0;
            index_q      <= probe_idx;
          end else begin
            index_miss_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_unit.sv
// Directed bench for mmu_unit: kernel segments, TLB mapping/exceptions, register
// commands and reset behaviour, all against hand-computed values.
module tb_mmu_unit;

  logic        clk = 1'b0;
  logic        res;
  logic        addrValid;
  logic [31:0] vAddr;
  logic [1:0]  mmu_accessType;
  logic [31:0] pAddr;
  logic        db_io;
  logic [1:0]  mmu_reg;
  logic [31:0] mmu_dataIn;
  logic [31:0] mmu_dataOut;
  logic [2:0]  mmu_cmd;
  logic [1:0]  mmu_exception;

  int total = 0;
  int bad   = 0;

  mmu_unit #(.TAG("MMU")) dut (
    .clk(clk), .res(res), .addrValid(addrValid), .vAddr(vAddr),
    .mmu_accessType(mmu_accessType), .pAddr(pAddr), .db_io(db_io),
    .mmu_reg(mmu_reg), .mmu_dataIn(mmu_dataIn), .mmu_dataOut(mmu_dataOut),
    .mmu_cmd(mmu_cmd), .mmu_exception(mmu_exception)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_xlat(input string tag, input logic [31:0] pa, input logic io,
                            input logic [1:0] exc);
    check({tag, ".pAddr"}, pAddr, pa);
    check({tag, ".db_io"}, 32'(db_io), 32'(io));
    check({tag, ".exc"}, 32'(mmu_exception), 32'(exc));
  endtask

  task automatic check_reg(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    mmu_reg = sel;
    #1;
    check(tag, mmu_dataOut, exp);
  endtask

  // Every stimulus task starts and ends at a falling edge.
  task automatic idle();
    @(negedge clk);
  endtask

  task automatic access(input logic [31:0] va, input logic [1:0] at);
    addrValid = 1'b1; vAddr = va; mmu_accessType = at;
    @(negedge clk);
    addrValid = 1'b0;
  endtask

  task automatic wr_reg(input logic [1:0] sel, input logic [31:0] data);
    mmu_reg = sel; mmu_dataIn = data; mmu_cmd = 3'd1;
    @(negedge clk);
    mmu_cmd = 3'd0;
  endtask

  task automatic issue(input logic [2:0] c);
    mmu_cmd = c;
    @(negedge clk);
    mmu_cmd = 3'd0;
  endtask

  initial begin
    res = 1'b0; addrValid = 1'b0; vAddr = '0; mmu_accessType = 2'd0;
    mmu_reg = 2'd0; mmu_dataIn = '0; mmu_cmd = 3'd0;
    idle(); idle();
    res = 1'b1;

    check_xlat("reset", 32'h0, 1'b0, 2'd0);
    check_reg("reset.index", 2'd0, 32'h0);
    check_reg("reset.hi", 2'd1, 32'h0);
    check_reg("reset.lo", 2'd2, 32'h0);
    check_reg("reset.bad", 2'd3, 32'h0);

    wr_reg(2'd3, 32'h1234_5678);
    check_reg("bad.wr_ignored", 2'd3, 32'h0);

    access(32'h8000_1234, 2'd1);
    check_xlat("kseg0", 32'h0000_1234, 1'b0, 2'd0);
    access(32'hBFC0_0000, 2'd1);
    check_xlat("kseg1", 32'h1FC0_0000, 1'b1, 2'd0);

    access(32'h0040_0010, 2'd3);
    check_xlat("miss", 32'h0, 1'b0, 2'd1);
    mmu_reg = 2'd3;
    idle();
    check_reg("bad.after_miss", 2'd3, 32'h0040_0010);

    // Field masking on writes
    wr_reg(2'd0, 32'h7FFF_FFFB);
    check_reg("index.mask", 2'd0, 32'h0000_0003);
    wr_reg(2'd1, 32'h0040_0ABC);
    check_reg("hi.mask", 2'd1, 32'h0040_0000);
    wr_reg(2'd2, 32'h0123_4FFF);
    check_reg("lo.mask", 2'd2, 32'h0123_4007);

    // Unused command code behaves as NONE
    mmu_reg = 2'd0; mmu_dataIn = 32'h0000_0006;
    issue(3'd5);
    check_reg("cmd5.none", 2'd0, 32'h0000_0003);

    // Still-latched 0x0040_0010 X access sees the new entry after TLBWI
    check_xlat("pre_tlbwi", 32'h0, 1'b0, 2'd1);
    issue(3'd2);
    check_xlat("latched.remap", 32'h0123_4010, 1'b1, 2'd0);

    access(32'h0040_0ABC, 2'd1);
    check_xlat("mapped.r", 32'h0123_4ABC, 1'b1, 2'd0);

    wr_reg(2'd2, 32'h0123_4001);
    issue(3'd2);
    access(32'h0040_0000, 2'd2);
    check_xlat("modify", 32'h0123_4000, 1'b0, 2'd3);

    wr_reg(2'd2, 32'h0123_4000);
    issue(3'd2);
    access(32'h0040_0000, 2'd1);
    check_xlat("invalid", 32'h0123_4000, 1'b0, 2'd2);
    access(32'h0040_0000, 2'd0);
    check_xlat("at_none", 32'h0123_4000, 1'b0, 2'd0);

    // Probe
    wr_reg(2'd0, 32'h0000_0005);
    wr_reg(2'd1, 32'h0040_0000);
    issue(3'd4);
    check_reg("tlbp.hit", 2'd0, 32'h0000_0003);
    wr_reg(2'd1, 32'h0050_0000);
    issue(3'd4);
    check_reg("tlbp.miss", 2'd0, 32'h8000_0003);

    // Read back entry 3
    wr_reg(2'd2, 32'hFFFF_F007);
    wr_reg(2'd0, 32'h0000_0003);
    issue(3'd3);
    check_reg("tlbr.hi", 2'd1, 32'h0040_0000);
    check_reg("tlbr.lo", 2'd2, 32'h0123_4000);

    // Duplicate VPN in entry 1: the lower index wins
    wr_reg(2'd0, 32'h0000_0001);
    wr_reg(2'd2, 32'h0AAA_A003);
    issue(3'd2);
    access(32'h0040_0ABC, 2'd2);
    check_xlat("dup.low_wins", 32'h0AAA_AABC, 1'b0, 2'd0);
    wr_reg(2'd0, 32'h0000_0007);
    issue(3'd4);
    check_reg("tlbp.dup", 2'd0, 32'h0000_0001);

    // Same-edge access and command
    wr_reg(2'd0, 32'h0000_0002);
    wr_reg(2'd1, 32'h0060_0000);
    wr_reg(2'd2, 32'h0077_7003);
    addrValid = 1'b1; vAddr = 32'h0060_0123; mmu_accessType = 2'd2;
    issue(3'd2);
    addrValid = 1'b0;
    check_xlat("same_edge", 32'h0077_7123, 1'b0, 2'd0);

    // Reset while a miss is showing
    access(32'h0070_0000, 2'd1);
    check_xlat("pre_reset", 32'h0, 1'b0, 2'd1);
    res = 1'b0;
    idle();
    res = 1'b1;
    check_xlat("mid_reset", 32'h0, 1'b0, 2'd0);
    check_reg("reset2.hi", 2'd1, 32'h0);
    access(32'h0040_0ABC, 2'd1);
    check_xlat("e_cleared", 32'h0, 1'b0, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
